// File: rtl/digit_serial_comparator.sv
// Multi-cycle G/E/L magnitude comparator: walks two WIDTH-bit operands MSB digit first,
// DIGIT bits per cycle, and stops at the first differing digit.
module digit_serial_comparator #(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               signed_mode,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    output logic                               busy,
    output logic                               done,
    output logic                               gt,
    output logic                               eq,
    output logic                               lt,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]   cycles
);

    localparam int ND = WIDTH / DIGIT;
    localparam int CW = $clog2(ND + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(ND - 1);
    localparam logic [CW-1:0] ALL_DIGITS = CW'(ND);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_comparator: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cycles_q, cycles_d;
    logic              gt_q, gt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;

    logic [WIDTH-1:0]  a_cap;
    logic [WIDTH-1:0]  b_cap;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;

    assign a_dig = a_sh_q[WIDTH-1 -: DIGIT];
    assign b_dig = b_sh_q[WIDTH-1 -: DIGIT];

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;

        // Flipping both sign bits maps two's-complement order onto unsigned order.
        a_cap = a;
        b_cap = b;
        if (SIGNED_EN != 0 && signed_mode) begin
            a_cap[WIDTH-1] = ~a[WIDTH-1];
            b_cap[WIDTH-1] = ~b[WIDTH-1];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COMPARE;
                    a_sh_d  = a_cap;
                    b_sh_d  = b_cap;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (a_dig != b_dig) begin
                    gt_d     = (a_dig > b_dig);
                    lt_d     = (a_dig < b_dig);
                    eq_d     = 1'b0;
                    cycles_d = cnt_q + CW'(1);
                    state_d  = S_DONE;
                end else if (cnt_q == LAST_DIGIT) begin
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b1;
                    cycles_d = ALL_DIGITS;
                    state_d  = S_DONE;
                end else begin
                    a_sh_d = a_sh_q << DIGIT;
                    b_sh_d = b_sh_q << DIGIT;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign busy   = (state_q == S_COMPARE);
    assign done   = (state_q == S_DONE);
    assign gt     = gt_q;
    assign eq     = eq_q;
    assign lt     = lt_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_digit_serial_comparator.sv
// Bench for digit_serial_comparator (WIDTH=16, DIGIT=4): directed cases plus random
// operands against an integer-arithmetic reference model.
module tb_digit_serial_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int ND    = WIDTH / DIGIT;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              signed_mode;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic              gt;
    logic              eq;
    logic              lt;
    logic [2:0]        cycles;

    int n_checks = 0;
    int n_pass   = 0;

    logic exp_gt_last, exp_eq_last, exp_lt_last;
    int   exp_cyc_last;

    digit_serial_comparator #(
        .WIDTH(WIDTH), .DIGIT(DIGIT), .SIGNED_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done),
        .gt(gt), .eq(eq), .lt(lt), .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: order from plain integer compare; digit count from the highest differing bit.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic sm,
                         output logic g, output logic e, output logic l, output int cyc);
        int ia, ib, p;
        logic [WIDTH-1:0] x;
        ia = sm ? int'($signed(ma)) : int'(ma);
        ib = sm ? int'($signed(mb)) : int'(mb);
        g = (ia > ib);
        e = (ia == ib);
        l = (ia < ib);
        x = ma ^ mb;
        if (x == '0) cyc = ND;
        else begin
            p = 0;
            for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
            cyc = (WIDTH - 1 - p) / DIGIT + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op from IDLE or DONE and returns in its done cycle, checking everything on the way.
    // inj: during the first busy cycle, drive a conflicting start that must be ignored.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic sm, input logic inj);
        logic eg, ee, el;
        int   ec, nb;
        model(ta, tb_v, sm, eg, ee, el, ec);
        a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_nooverlap"}, {30'd0, done, busy}, 32'h1);
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            if (inj && nb == 1) begin
                a = '0; b = 16'hFFFF; start = 1'b1; signed_mode = 1'b0;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, "_busycyc"}, nb, ec);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_gel"}, {29'd0, gt, eq, lt}, {29'd0, eg, ee, el});
        chk({tag, "_cycles"}, cycles, ec);
        exp_gt_last = eg; exp_eq_last = ee; exp_lt_last = el; exp_cyc_last = ec;
    endtask

    task automatic go_idle(input string tag);
        tick();
        chk({tag, "_donedrop"}, {30'd0, done, busy}, 32'h0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic rs;
        int   nd_seen;

        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        chk("reset_outs", {26'd0, busy, done, gt, eq, lt, 1'b0}, 32'h0);
        chk("reset_cycles", cycles, 0);
        rst_n = 1'b1;
        tick();

        run_op("t1_unsigned", 16'hF000, 16'h1000, 1'b0, 1'b0);
        chk("t1_gt", gt, 1'b1);
        go_idle("t1");
        run_op("t2_signed", 16'hF000, 16'h1000, 1'b1, 1'b0);
        chk("t2_lt", lt, 1'b1);
        go_idle("t2");
        run_op("t3_equal", 16'h1234, 16'h1234, 1'b0, 1'b0);
        chk("t3_eq", eq, 1'b1);
        go_idle("t3");
        run_op("t4_busy_ignore", 16'h1235, 16'h1234, 1'b0, 1'b1);
        chk("t4_gt", gt, 1'b1);
        run_op("t5_b2b", 16'h0000, 16'h0001, 1'b0, 1'b0);
        chk("t5_lt", lt, 1'b1);
        go_idle("t5");

        // Reset in the second COMPARE cycle abandons the operation.
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_outs", {26'd0, busy, done, gt, eq, lt, 1'b0}, 32'h0);
        chk("t6_rst_cycles", cycles, 0);
        nd_seen = 0;
        repeat (6) begin
            tick();
            if (done || busy) nd_seen++;
        end
        chk("t6_no_done", nd_seen, 0);
        run_op("t6_fresh", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        go_idle("t6");

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h000F << (4 * $urandom_range(0, 3))) & 16'($urandom);
                2: rb = ra ^ 16'(1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            rs = 1'($urandom);
            run_op("rand", ra, rb, rs, 1'($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 0) go_idle("rand");
        end
        go_idle("final");

        repeat (3) tick();
        chk("hold_gel", {29'd0, gt, eq, lt}, {29'd0, exp_gt_last, exp_eq_last, exp_lt_last});
        chk("hold_cycles", cycles, exp_cyc_last);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
